// File: rtl/display_scan_mux.sv
// 4-digit 7-segment scan multiplexer with inter-digit blanking and decimal point.
// Optional SCAN_DIM_EN macro enables brightness-controlled dimming of the active window.
module display_scan_mux #(
  parameter int       SLOT_CYCLES   = 25000,
  parameter int       BLANK_CYCLES  = 64,
  parameter bit       AN_ACTIVE_LOW = 1'b1,
  parameter bit       DP_ACTIVE_LOW = 1'b1,
  parameter logic [6:0] SEG_OFF     = 7'h7F
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] seg_in1,
  input  logic [6:0] seg_in2,
  input  logic [6:0] seg_in3,
  input  logic [6:0] seg_in4,
  input  logic [2:0] brightness,
  output logic [6:0] seg_out,
  output logic       dp_out,
  output logic [3:0] an_out,
  output logic       slot_tick
);

  localparam int CW = (SLOT_CYCLES > 2) ? $clog2(SLOT_CYCLES) : 1;
  localparam logic [CW-1:0] LAST  = CW'(SLOT_CYCLES - 1);
  localparam logic [CW-1:0] BLANK = CW'(BLANK_CYCLES);
  localparam logic [3:0] AN_OFF = AN_ACTIVE_LOW ? 4'hF : 4'h0;
  localparam logic DP_ON = ~DP_ACTIVE_LOW;

  logic [CW-1:0] slot_cnt_q, slot_cnt_d;
  logic [1:0]    digit_q, digit_d;
  logic [6:0]    hold_q, hold_d;
  logic [6:0]    seg_q, seg_d;
  logic          dp_q, dp_d;
  logic [3:0]    an_q, an_d;
  logic          tick_q, tick_d;

  logic          start;
  logic          active;
  logic [6:0]    sel;
  logic [6:0]    cur;
  logic [3:0]    onehot;

`ifdef SCAN_DIM_EN
  localparam logic [31:0] WIN = 32'(SLOT_CYCLES - BLANK_CYCLES);
  logic [2:0]  bright_q, bright_d;
  logic [31:0] dim_off;
  logic [31:0] dim_phase;
`else
  logic unused_bright;
  assign unused_bright = ^brightness;
`endif

  always_comb begin
    sel    = seg_in1;
    onehot = 4'b1000;
    unique case (digit_q)
      2'd0: begin sel = seg_in1; onehot = 4'b1000; end
      2'd1: begin sel = seg_in2; onehot = 4'b0100; end
      2'd2: begin sel = seg_in3; onehot = 4'b0010; end
      2'd3: begin sel = seg_in4; onehot = 4'b0001; end
    endcase

    start      = (slot_cnt_q == '0);
    slot_cnt_d = (slot_cnt_q == LAST) ? '0 : slot_cnt_q + 1'b1;
    digit_d    = (slot_cnt_q == LAST) ? digit_q + 2'd1 : digit_q;

    // bypass the holding register on the capture cycle itself
    cur    = start ? sel : hold_q;
    hold_d = cur;
    active = (slot_cnt_q >= BLANK);

`ifdef SCAN_DIM_EN
    bright_d  = start ? brightness : bright_q;
    dim_off   = 32'(slot_cnt_q) - 32'(BLANK_CYCLES);
    dim_phase = (dim_off * 32'd8) / WIN;
    active    = active && (dim_phase <= 32'(bright_d));
`endif

    an_d   = active ? (AN_ACTIVE_LOW ? ~onehot : onehot) : AN_OFF;
    seg_d  = active ? cur : SEG_OFF;
    dp_d   = (active && digit_q == 2'd2) ? DP_ON : ~DP_ON;
    tick_d = start;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      slot_cnt_q <= '0;
      digit_q    <= 2'd0;
      hold_q     <= SEG_OFF;
      seg_q      <= SEG_OFF;
      dp_q       <= ~DP_ON;
      an_q       <= AN_OFF;
      tick_q     <= 1'b0;
    end else begin
      slot_cnt_q <= slot_cnt_d;
      digit_q    <= digit_d;
      hold_q     <= hold_d;
      seg_q      <= seg_d;
      dp_q       <= dp_d;
      an_q       <= an_d;
      tick_q     <= tick_d;
    end
  end

`ifdef SCAN_DIM_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) bright_q <= 3'd7;
    else       bright_q <= bright_d;
  end
`endif

  assign seg_out   = seg_q;
  assign dp_out    = dp_q;
  assign an_out    = an_q;
  assign slot_tick = tick_q;

endmodule

// File: tb/tb_display_scan_mux.sv
// Directed bench for display_scan_mux: reset, frame timing, capture, invariants,
// dimming, and inverted anode/dp polarity via a second instance.
module tb_display_scan_mux;

  logic       clk;
  logic       reset;
  logic [6:0] seg_in1, seg_in2, seg_in3, seg_in4;
  logic [2:0] brightness;
  logic [6:0] seg_out, seg_out_n;
  logic       dp_out, dp_out_n;
  logic [3:0] an_out, an_out_n;
  logic       slot_tick, slot_tick_n;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  display_scan_mux #(
    .SLOT_CYCLES(16), .BLANK_CYCLES(2)
  ) u_dut (
    .clk(clk), .reset(reset),
    .seg_in1(seg_in1), .seg_in2(seg_in2),
    .seg_in3(seg_in3), .seg_in4(seg_in4),
    .brightness(brightness),
    .seg_out(seg_out), .dp_out(dp_out),
    .an_out(an_out), .slot_tick(slot_tick)
  );

  display_scan_mux #(
    .SLOT_CYCLES(16), .BLANK_CYCLES(2),
    .AN_ACTIVE_LOW(1'b0), .DP_ACTIVE_LOW(1'b0)
  ) u_inv (
    .clk(clk), .reset(reset),
    .seg_in1(seg_in1), .seg_in2(seg_in2),
    .seg_in3(seg_in3), .seg_in4(seg_in4),
    .brightness(brightness),
    .seg_out(seg_out_n), .dp_out(dp_out_n),
    .an_out(an_out_n), .slot_tick(slot_tick_n)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  task automatic run_to(input int k);
    while (cyc < k) step();
  endtask

  logic [6:0] pat [4];
  logic [3:0] an_exp;
  logic [6:0] seg_exp;
  logic       dp_exp;
  int c, d;
  int bad, bad_inv, bad_tick;
  int lowcnt [4];
  int gap, last_tick, nticks, seen, act;
  logic [3:0] prev_an;
  logic have_prev;

  initial begin
    pat[0] = 7'h40; pat[1] = 7'h79;
    pat[2] = 7'h24; pat[3] = 7'h30;
    seg_in1 = pat[0]; seg_in2 = pat[1];
    seg_in3 = pat[2]; seg_in4 = pat[3];
    brightness = 3'd7;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (21) step();

    // asynchronous reset mid-run
    #2 reset = 1'b1;
    #1;
    check("rst_an", 32'(an_out), 32'hF);
    check("rst_seg", 32'(seg_out), 32'h7F);
    check("rst_dp", 32'(dp_out), 32'h1);
    check("rst_tick", 32'(slot_tick), 32'h0);
    check("rst_an_inv", 32'(an_out_n), 32'h0);
    check("rst_dp_inv", 32'(dp_out_n), 32'h0);
    @(negedge clk);
    reset = 1'b0;
    cyc = 0;

    // one full frame after release
    bad = 0; bad_inv = 0; bad_tick = 0;
    for (int i = 0; i < 4; i++) lowcnt[i] = 0;
    for (int k = 1; k <= 64; k++) begin
      step();
      c = (k - 1) % 16;
      d = ((k - 1) / 16) % 4;
      if (c >= 2) begin
        an_exp  = ~(4'b1000 >> d);
        seg_exp = pat[d];
        dp_exp  = (d == 2) ? 1'b0 : 1'b1;
      end else begin
        an_exp  = 4'hF;
        seg_exp = 7'h7F;
        dp_exp  = 1'b1;
      end
      if (k == 1) check("first_tick", 32'(slot_tick), 32'h1);
      if (k == 2) check("blank_an", 32'(an_out), 32'hF);
      if (k == 3) check("first_an", 32'(an_out), 32'h7);
      if (an_out !== an_exp || seg_out !== seg_exp ||
          dp_out !== dp_exp) bad++;
      if (an_out_n !== ~an_exp || seg_out_n !== seg_exp ||
          dp_out_n !== ~dp_exp) bad_inv++;
      if (slot_tick !== (c == 0)) bad_tick++;
      for (int j = 0; j < 4; j++)
        if (an_out[3-j] === 1'b0) lowcnt[j]++;
    end
    check("frame_cycles", 32'(bad), 32'd0);
    check("frame_inv", 32'(bad_inv), 32'd0);
    check("frame_tick", 32'(bad_tick), 32'd0);
    check("low_an3", 32'(lowcnt[0]), 32'd14);
    check("low_an2", 32'(lowcnt[1]), 32'd14);
    check("low_an1", 32'(lowcnt[2]), 32'd14);
    check("low_an0", 32'(lowcnt[3]), 32'd14);

    // capture: change during slot 0, then during slot 2
    run_to(66);
    seg_in3 = 7'h19;
    run_to(102);
    check("cap_new_seg", 32'(seg_out), 32'h19);
    check("cap_new_an", 32'(an_out), 32'hD);
    seg_in3 = 7'h24;
    run_to(105);
    check("cap_hold", 32'(seg_out), 32'h19);
    run_to(165);
    check("cap_next", 32'(seg_out), 32'h24);
    check("cap_next_dp", 32'(dp_out), 32'h0);

    // 1000-cycle invariants
    bad = 0; gap = 0; last_tick = 0; nticks = 0;
    have_prev = 1'b0; prev_an = 4'hF;
    for (int k = 0; k < 1000; k++) begin
      step();
      if ($countones(~an_out) > 1) bad++;
      if (an_out === 4'hF) gap++;
      else begin
        if (have_prev && an_out !== prev_an && gap < 2) bad++;
        prev_an = an_out;
        have_prev = 1'b1;
        gap = 0;
      end
      if (slot_tick) begin
        if (last_tick > 0 && cyc - last_tick != 16) bad++;
        last_tick = cyc;
        nticks++;
      end
    end
    check("inv_errors", 32'(bad), 32'd0);
    check("inv_ticks", 32'(nticks >= 62), 32'd1);

    // dimming (ignored when SCAN_DIM_EN is undefined)
    for (int b = 0; b < 2; b++) begin
      brightness = (b == 0) ? 3'd3 : 3'd7;
      seen = 0;
      for (int i = 0; i < 40 && seen < 2; i++) begin
        step();
        if (slot_tick) seen++;
      end
      check("dim_sync", 32'(seen), 32'd2);
      act = (an_out !== 4'hF) ? 1 : 0;
      for (int i = 0; i < 15; i++) begin
        step();
        if (an_out !== 4'hF) act++;
        if (an_out === 4'hF && seg_out !== 7'h7F) act += 100;
      end
`ifdef SCAN_DIM_EN
      check("dim_active", 32'(act), (b == 0) ? 32'd7 : 32'd14);
`else
      check("dim_active", 32'(act), 32'd14);
`endif
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
